countdown_ctrl: RTL and testbench
=================================

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, the clock frequency in Hz and the number of cycles per 1 s tick.
REQ-002 SHALL have parameter ALARM_SECS, default 10, the auto-silence ring duration in seconds.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on posedge CLK.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port START  input  1  debounced single-cycle pulse: start/pause/resume/acknowledge.
REQ-006 SHALL have port STOP  input  1  debounced single-cycle pulse: abort to IDLE.
REQ-007 SHALL have port SET_MIN  input  1  debounced pulse: increment preset minutes.
REQ-008 SHALL have port SET_SEC  input  1  debounced pulse: increment preset seconds.
REQ-009 SHALL have port MIN_BCD  output  8  displayed minutes, two BCD digits.
REQ-010 SHALL have port SEC_BCD  output  8  displayed seconds, two BCD digits.
REQ-011 SHALL have port ALARM_EN  output  1  registered enable for the downstream buzzer-tone block.
REQ-012 SHALL have port RUNNING  output  1  high only in state RUN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, RING.
REQ-014 SHALL hold a preset (min 00-99, sec 00-59) and a live count, both BCD; MIN_BCD/SEC_BCD show the preset in IDLE and the live count otherwise.
REQ-015 SHALL apply SET_MIN in IDLE only: preset min +1, 99 wraps to 00; SET_SEC in IDLE only: preset sec +1, 59 wraps to 00; ignored in other states.
REQ-016 SHALL apply START in IDLE: preset 00:00 is ignored; otherwise live count loads preset and the FSM enters RUN.
REQ-017 SHALL apply START in RUN to PAUSE, in PAUSE to RUN (live count held), and in RING to IDLE.
REQ-018 SHALL apply STOP in any state to IDLE; the preset is retained.
REQ-019 SHALL generate the 1 s tick with a prescaler counting 0..CLK_HZ-1, pulsing one cycle at CLK_HZ-1; the prescaler runs only in RUN and RING and clears to 0 on every state change, so the first second after entry is a full CLK_HZ cycles.
REQ-020 SHALL decrement the live count on a tick in RUN: sec 00 to 59 with min -1; BCD digit borrow (x0 to (x-1)9).
REQ-021 SHALL, when a tick takes the live count from 00:01 to 00:00, enter RING in the same edge; ALARM_EN is high from the next cycle.
REQ-022 SHALL hold ALARM_EN high exactly while in RING; the live count shows 00:00 throughout RING.
REQ-023 SHALL resolve simultaneous events as: STOP beats START beats SET_*; START beats tick in RUN (pause, no decrement).
REQ-024 SHALL register all outputs, with no combinational input-to-output path.

Reset
REQ-025 SHALL, when RST_N is low at a posedge, set state IDLE, preset 00:00, live count 00:00, and prescaler 0.
REQ-026 SHALL drive ALARM_EN=0, RUNNING=0, MIN_BCD=8'h00 and SEC_BCD=8'h00 from the first edge in reset.
REQ-027 SHALL give reset priority over all inputs, including mid-RUN and mid-RING.

Configuration
REQ-028 SHALL, when COUNTDOWN_AUTOSILENCE_EN is defined, count ticks in RING and go to IDLE on the ALARM_SECS-th tick, with ALARM_EN low the following cycle.
REQ-029 SHALL, when COUNTDOWN_AUTOSILENCE_EN is undefined, keep RING until START or STOP; ALARM_SECS is unused.

Structure
REQ-030 SHALL place the FSM state enum and BCD limit constants (8'h59, 8'h99) in package countdown_pkg.
REQ-031 SHALL implement the prescaler as sub-module tick_gen (parameter CLK_HZ; inputs CLK, RST_N, clr, en; output tick).
REQ-032 SHALL implement BCD increment/decrement as functions in countdown_pkg.

Verification (CLK_HZ=10, ALARM_SECS=3)
REQ-033 SHALL cover: 3x SET_SEC, START -> RUNNING=1; SEC_BCD 03,02,01 at 10-cycle intervals; at 00 ALARM_EN=1 one cycle later.
REQ-034 SHALL cover: preset 01:00, START, one tick -> MIN_BCD=00, SEC_BCD=59.
REQ-035 SHALL cover: 60x SET_SEC -> preset sec 00; 100x SET_MIN -> preset min 00; START at 00:00 -> stays IDLE.
REQ-036 SHALL cover: RUN at 00:05, START, wait 50 cycles, START -> count still 00:05 while paused; resumes with a full 10-cycle first second.
REQ-037 SHALL cover: START and STOP in the same cycle during RUN -> IDLE, display shows preset; RST_N low mid-RING -> ALARM_EN=0 next edge, all outputs 0.
REQ-038 SHALL cover: RING with COUNTDOWN_AUTOSILENCE_EN defined -> ALARM_EN drops after 30 cycles; without it -> ALARM_EN stays high until START.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared FSM state type, BCD limits and BCD step helpers for countdown_ctrl.
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h99;

    // Two-digit BCD increment that wraps from lim back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    // Two-digit BCD decrement; 00 wraps to lim, x0 borrows to (x-1)9.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
        if (v == 8'h00)
            return lim;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while en, tick is high on the last count.
module tick_gen #(
    parameter int CLK_HZ = 12000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// Kitchen-timer style countdown controller (IDLE/RUN/PAUSE/RING) with BCD display.
// Define COUNTDOWN_AUTOSILENCE_EN to end RING automatically after ALARM_SECS seconds.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int ALARM_SECS = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       STOP,
    input  logic       SET_MIN,
    input  logic       SET_SEC,
    output logic [7:0] MIN_BCD,
    output logic [7:0] SEC_BCD,
    output logic       ALARM_EN,
    output logic       RUNNING
);

    state_t     state, nxt;
    logic [7:0] pre_min, pre_sec, live_min, live_sec;
    logic [7:0] nxt_pre_min, nxt_pre_sec, nxt_live_min, nxt_live_sec;
    logic       tick, ring_done;

    // Any state change restarts the second so the first one after entry is full length.
    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .CLK  (CLK),
        .RST_N(RST_N),
        .clr  (nxt != state),
        .en   (state == RUN || state == RING),
        .tick (tick)
    );

`ifdef COUNTDOWN_AUTOSILENCE_EN
    localparam int RING_W = $clog2(ALARM_SECS + 1);
    logic [RING_W-1:0] ring_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N || state != RING)
            ring_cnt <= '0;
        else if (tick)
            ring_cnt <= ring_cnt + RING_W'(1);
    end

    assign ring_done = tick && (ring_cnt == RING_W'(ALARM_SECS - 1));
`else
    assign ring_done = 1'b0;
`endif

    always_comb begin
        nxt          = state;
        nxt_pre_min  = pre_min;
        nxt_pre_sec  = pre_sec;
        nxt_live_min = live_min;
        nxt_live_sec = live_sec;
        if (STOP) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        if ({pre_min, pre_sec} != 16'h0000) begin
                            nxt          = RUN;
                            nxt_live_min = pre_min;
                            nxt_live_sec = pre_sec;
                        end
                    end else begin
                        if (SET_MIN) nxt_pre_min = bcd_inc(pre_min, MIN_MAX);
                        if (SET_SEC) nxt_pre_sec = bcd_inc(pre_sec, SEC_MAX);
                    end
                end
                RUN: begin
                    if (START) begin
                        nxt = PAUSE;
                    end else if (tick) begin
                        if (live_min == 8'h00 && live_sec == 8'h01) begin
                            nxt_live_sec = 8'h00;
                            nxt          = RING;
                        end else if (live_sec == 8'h00) begin
                            nxt_live_sec = SEC_MAX;
                            nxt_live_min = bcd_dec(live_min, MIN_MAX);
                        end else begin
                            nxt_live_sec = bcd_dec(live_sec, SEC_MAX);
                        end
                    end
                end
                PAUSE: if (START) nxt = RUN;
                RING:  if (START || ring_done) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state values so they track the state exactly.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            pre_min  <= 8'h00;
            pre_sec  <= 8'h00;
            live_min <= 8'h00;
            live_sec <= 8'h00;
            MIN_BCD  <= 8'h00;
            SEC_BCD  <= 8'h00;
            ALARM_EN <= 1'b0;
            RUNNING  <= 1'b0;
        end else begin
            state    <= nxt;
            pre_min  <= nxt_pre_min;
            pre_sec  <= nxt_pre_sec;
            live_min <= nxt_live_min;
            live_sec <= nxt_live_sec;
            MIN_BCD  <= (nxt == IDLE) ? nxt_pre_min : nxt_live_min;
            SEC_BCD  <= (nxt == IDLE) ? nxt_pre_sec : nxt_live_sec;
            ALARM_EN <= (nxt == RING);
            RUNNING  <= (nxt == RUN);
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with CLK_HZ=10 (10-cycle seconds) and ALARM_SECS=3.
module tb_countdown_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0, STOP = 1'b0, SET_MIN = 1'b0, SET_SEC = 1'b0;
    logic [7:0] MIN_BCD, SEC_BCD;
    logic       ALARM_EN, RUNNING;

    int checks = 0;
    int errors = 0;

    countdown_ctrl #(.CLK_HZ(10), .ALARM_SECS(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
        .SET_MIN(SET_MIN), .SET_SEC(SET_SEC),
        .MIN_BCD(MIN_BCD), .SEC_BCD(SEC_BCD), .ALARM_EN(ALARM_EN), .RUNNING(RUNNING)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n, start, stop, smin, ssec;
        logic [7:0] emin, esec;
        logic       ealarm, erun;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic st, input logic sp, input logic sm, input logic ss);
        START = st; STOP = sp; SET_MIN = sm; SET_SEC = ss;
        step();
        START = 1'b0; STOP = 1'b0; SET_MIN = 1'b0; SET_SEC = 1'b0;
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] emin, input logic [7:0] esec,
                           input logic ealarm, input logic erun);
        checks++;
        if (MIN_BCD !== emin || SEC_BCD !== esec || ALARM_EN !== ealarm || RUNNING !== erun) begin
            errors++;
            $display("FAIL %s: got %h:%h alarm=%b run=%b expected %h:%h alarm=%b run=%b",
                     name, MIN_BCD, SEC_BCD, ALARM_EN, RUNNING, emin, esec, ealarm, erun);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst start stop smin ssec  min    sec   alarm run
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h03, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h03, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h03, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

        step();
        for (int i = 0; i < 15; i++) begin
            RST_N = vecs[i].rst_n;
            drive(vecs[i].start, vecs[i].stop, vecs[i].smin, vecs[i].ssec);
            chk_all($sformatf("vec%0d", i), vecs[i].emin, vecs[i].esec, vecs[i].ealarm, vecs[i].erun);
        end
        RST_N = 1'b1;

        // 00:03 countdown into RING
        do_reset();
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("a_preset", 8'h00, 8'h03, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("a_start", 8'h00, 8'h03, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            repeat (9) step();
            chk_all($sformatf("a_hold%0d", k), 8'h00, 8'(3 - k), 1'b0, 1'b1);
            step();
            if (k < 2)
                chk_all($sformatf("a_tick%0d", k), 8'h00, 8'(2 - k), 1'b0, 1'b1);
            else
                chk_all("a_ring", 8'h00, 8'h00, 1'b1, 1'b0);
        end
`ifdef COUNTDOWN_AUTOSILENCE_EN
        repeat (29) step();
        chk_all("a_ring_29", 8'h00, 8'h00, 1'b1, 1'b0);
        step();
        chk_all("a_autosilence", 8'h00, 8'h03, 1'b0, 1'b0);
`else
        repeat (40) step();
        chk_all("a_ring_held", 8'h00, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("a_ring_ack", 8'h00, 8'h03, 1'b0, 1'b0);
`endif

        // Minute borrow 01:00 -> 00:59 -> 00:58
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("b_preset", 8'h01, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (9) step();
        chk_all("b_hold", 8'h01, 8'h00, 1'b0, 1'b1);
        step();
        chk_all("b_borrow", 8'h00, 8'h59, 1'b0, 1'b1);
        repeat (10) step();
        chk_all("b_58", 8'h00, 8'h58, 1'b0, 1'b1);

        // Tens-digit borrows: 10:00 -> 09:59 and 00:10 -> 00:09
        do_reset();
        repeat (10) drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("b_min10", 8'h10, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        chk_all("b_0959", 8'h09, 8'h59, 1'b0, 1'b1);
        do_reset();
        repeat (10) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("b_sec10", 8'h00, 8'h10, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        chk_all("b_0009", 8'h00, 8'h09, 1'b0, 1'b1);

        // Preset wraps and START at 00:00
        do_reset();
        repeat (59) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk8("c_sec59", SEC_BCD, 8'h59);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk8("c_sec_wrap", SEC_BCD, 8'h00);
        repeat (99) drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk8("c_min99", MIN_BCD, 8'h99);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk8("c_min_wrap", MIN_BCD, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("c_start_zero", 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (12) step();
        chk_all("c_still_idle", 8'h00, 8'h00, 1'b0, 1'b0);

        // Pause/resume at 00:05, START beating a tick
        do_reset();
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("d_pause", 8'h00, 8'h05, 1'b0, 1'b0);
        repeat (50) step();
        chk_all("d_paused50", 8'h00, 8'h05, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("d_resume", 8'h00, 8'h05, 1'b0, 1'b1);
        repeat (9) step();
        chk8("d_full_second", SEC_BCD, 8'h05);
        step();
        chk8("d_tick", SEC_BCD, 8'h04);
        repeat (9) step();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("d_start_beats_tick", 8'h00, 8'h04, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        chk_all("d_resume2", 8'h00, 8'h03, 1'b0, 1'b1);

        // START+STOP together in RUN: STOP wins, display back to preset
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("e_stop_beats_start", 8'h00, 8'h05, 1'b0, 1'b0);

        // STOP in RING
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        chk_all("e_ring", 8'h00, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("e_stop_ring", 8'h00, 8'h01, 1'b0, 1'b0);

        // Reset mid-RING
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        chk_all("e_ring2", 8'h00, 8'h00, 1'b1, 1'b0);
        repeat (2) step();
        RST_N = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("e_rst_ring", 8'h00, 8'h00, 1'b0, 1'b0);
        RST_N = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("e_after_rst", 8'h00, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
